// File: rtl/reg_sched_pkg.sv
// Shared types and default sizes for the register-file write scheduler.
package reg_sched_pkg;

  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_NREG   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is port A, bit 1 is port B.
module rr_arb2
  import reg_sched_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  port_id_t last;

  // One-hot grant; on contention the port that did not win last time goes
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = (last == PORT_B) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the winner of each actual transfer
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last <= PORT_B;
    end else if (gnt != 2'b00) begin
      last <= gnt[1] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/reg_write_sched.sv
// Shares the register file write port between ALU (A) and load (B) writeback
// and runs a sequenced clear that zeroes every register.
module reg_write_sched
  import reg_sched_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NREG   = REG_NREG
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_READY,
  input  logic              CLEAR_REQ,
  output logic              CLEAR_BUSY,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              clr_done;

  // Ports may only be granted while idle and no clear is being requested
  assign arb_en = (state == IDLE) && !CLEAR_REQ;

  // The clear is finished once the last register's zero write is on the port
  assign clr_done = WR_EN && (WR_ADDR == ADDR_W'(NREG - 1));

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RESET  (RESET),
    .req    ({B_VALID, A_VALID}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enter CLEAR on a sampled request, leave after the final write
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLEAR_REQ) state_nxt = CLEAR;
      CLEAR:   if (clr_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: handshakes, busy flag and the next write-port contents
  always_comb begin
    A_READY     = gnt[0];
    B_READY     = gnt[1];
    CLEAR_BUSY  = (state == CLEAR);
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = WR_ADDR;
    wr_data_nxt = WR_DATA;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        if (CLEAR_REQ) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = cnt;
          wr_data_nxt = '0;
          cnt_nxt     = cnt + ADDR_W'(1);
        end else if (gnt[0]) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = A_ADDR;
          wr_data_nxt = A_DATA;
        end else if (gnt[1]) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = B_ADDR;
          wr_data_nxt = B_DATA;
        end
      end
      CLEAR: begin
        if (clr_done) begin
          cnt_nxt = '0;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = cnt;
          wr_data_nxt = '0;
          cnt_nxt     = cnt + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered write port and clear address counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WR_EN   <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
      cnt     <= '0;
    end else begin
      WR_EN   <= wr_en_nxt;
      WR_ADDR <= wr_addr_nxt;
      WR_DATA <= wr_data_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_sched.sv
// Bench for reg_write_sched: directed scenarios plus random traffic, checked
// cycle by cycle against a schedule-level model of the write port.
module tb_reg_write_sched;
  import reg_sched_pkg::*;

  localparam int unsigned AW = REG_ADDR_W;
  localparam int unsigned DW = REG_DATA_W;
  localparam int unsigned NR = REG_NREG;

  logic          CLK;
  logic          RESET;
  logic          A_VALID, A_READY, B_VALID, B_READY;
  logic [AW-1:0] A_ADDR, B_ADDR, WR_ADDR;
  logic [DW-1:0] A_DATA, B_DATA, WR_DATA;
  logic          CLEAR_REQ, CLEAR_BUSY, WR_EN;

  reg_write_sched dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .A_VALID    (A_VALID),
    .A_ADDR     (A_ADDR),
    .A_DATA     (A_DATA),
    .A_READY    (A_READY),
    .B_VALID    (B_VALID),
    .B_ADDR     (B_ADDR),
    .B_DATA     (B_DATA),
    .B_READY    (B_READY),
    .CLEAR_REQ  (CLEAR_REQ),
    .CLEAR_BUSY (CLEAR_BUSY),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  // Requesters: pending request per port fed from a queue or at random
  req_t aq[$], bq[$];
  req_t a_r, b_r;
  bit   a_v, b_v;
  int   clr_hold;
  bit   rnd_mode;

  // Model: edge index, edge at which the latest clear was sampled, arbitration
  // history and the write-port contents expected after the last edge
  int            cyc;
  int            clr_start;
  bit            last_b;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] s_regs [NR];
  logic [DW-1:0] wlog[$];
  int            busy_cnt;

  // A clear sampled at edge k keeps the port busy during cycles k+1..k+NR
  function automatic bit busy_at(int t);
    return (t >= clr_start + 1) && (t <= clr_start + int'(NR));
  endfunction

  task automatic model_reset();
    cyc       = 0;
    clr_start = -1000;
    last_b    = 1'b1;
    m_en      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    a_v       = 1'b0;
    b_v       = 1'b0;
    clr_hold  = 0;
  endtask

  task automatic step();
    bit busy, clr, ea, eb;
    @(negedge CLK);
    busy = busy_at(cyc);
    check("wr_en",      WR_EN,      m_en);
    check("wr_addr",    WR_ADDR,    m_addr);
    check("wr_data",    WR_DATA,    m_data);
    check("clear_busy", CLEAR_BUSY, busy);
    if (WR_EN) begin
      s_regs[WR_ADDR] = WR_DATA;
      wlog.push_back(WR_DATA);
    end
    if (m_en) m_regs[m_addr] = m_data;
    if (CLEAR_BUSY) busy_cnt++;

    if (!a_v) begin
      if (aq.size() > 0) begin a_r = aq.pop_front(); a_v = 1'b1; end
      else if (rnd_mode && $urandom_range(2) == 0) begin
        a_r.addr = AW'($urandom); a_r.data = DW'($urandom); a_v = 1'b1;
      end
    end
    if (!b_v) begin
      if (bq.size() > 0) begin b_r = bq.pop_front(); b_v = 1'b1; end
      else if (rnd_mode && $urandom_range(2) == 0) begin
        b_r.addr = AW'($urandom); b_r.data = DW'($urandom); b_v = 1'b1;
      end
    end
    clr = (clr_hold > 0);
    if (clr_hold > 0) clr_hold--;
    if (rnd_mode && clr_hold == 0 && $urandom_range(39) == 0) clr_hold = int'($urandom_range(12, 1));

    A_VALID   = a_v;
    A_ADDR    = a_v ? a_r.addr : AW'($urandom);
    A_DATA    = a_v ? a_r.data : DW'($urandom);
    B_VALID   = b_v;
    B_ADDR    = b_v ? b_r.addr : AW'($urandom);
    B_DATA    = b_v ? b_r.data : DW'($urandom);
    CLEAR_REQ = clr;
    #1;

    ea = 1'b0;
    eb = 1'b0;
    if (!busy && !clr) begin
      if (a_v && b_v) begin ea = last_b; eb = !last_b; end
      else begin ea = a_v; eb = b_v; end
    end
    check("a_ready", A_READY, ea);
    check("b_ready", B_READY, eb);

    if (!busy && clr) begin
      clr_start = cyc; m_en = 1'b1; m_addr = '0; m_data = '0;
    end else if (ea) begin
      m_en = 1'b1; m_addr = a_r.addr; m_data = a_r.data; a_v = 1'b0; last_b = 1'b0;
    end else if (eb) begin
      m_en = 1'b1; m_addr = b_r.addr; m_data = b_r.data; b_v = 1'b0; last_b = 1'b1;
    end else if (busy_at(cyc + 1)) begin
      m_en = 1'b1; m_addr = AW'(cyc - clr_start); m_data = '0;
    end else begin
      m_en = 1'b0;
    end
    cyc++;
  endtask

  task automatic apply_reset(input int cycles);
    RESET     = 1'b0;
    A_VALID   = 1'b0;
    B_VALID   = 1'b0;
    CLEAR_REQ = 1'b0;
    #1;
    check("rst_wr_en",   WR_EN,      0);
    check("rst_wr_addr", WR_ADDR,    0);
    check("rst_wr_data", WR_DATA,    0);
    check("rst_busy",    CLEAR_BUSY, 0);
    repeat (cycles) @(negedge CLK);
    RESET = 1'b1;
    model_reset();
  endtask

  initial begin
    RESET     = 1'b1;
    A_VALID   = 1'b0; A_ADDR = '0; A_DATA = '0;
    B_VALID   = 1'b0; B_ADDR = '0; B_DATA = '0;
    CLEAR_REQ = 1'b0;
    rnd_mode  = 1'b0;
    busy_cnt  = 0;
    for (int i = 0; i < int'(NR); i++) begin m_regs[i] = '0; s_regs[i] = '0; end
    model_reset();
    #3;
    apply_reset(2);

    // Single A write with one-cycle latency
    aq.push_back('{addr: AW'(3), data: DW'(8'h5A)});
    repeat (4) step();
    check("single_cnt", wlog.size(), 1);
    if (wlog.size() >= 1) check("single_data", wlog[0], 8'h5A);

    // Continuous contention alternates A, B, A, B
    apply_reset(1);
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      aq.push_back('{addr: AW'(1), data: DW'(10 + i)});
      bq.push_back('{addr: AW'(2), data: DW'(20 + i)});
    end
    repeat (12) step();
    check("rr_cnt", wlog.size(), 8);
    if (wlog.size() >= 4) begin
      check("rr_0", wlog[0], 10);
      check("rr_1", wlog[1], 20);
      check("rr_2", wlog[2], 11);
      check("rr_3", wlog[3], 21);
    end

    // Clear pulse with A held: eight zero writes, then A
    wlog.delete();
    busy_cnt = 0;
    aq.push_back('{addr: AW'(4), data: DW'(8'h77)});
    clr_hold = 1;
    repeat (14) step();
    check("clr_busy_cycles", busy_cnt, 8);
    check("clr_write_cnt", wlog.size(), 9);
    if (wlog.size() >= 9) check("clr_then_a", wlog[8], 8'h77);

    // Clear held for 20 cycles: three sequences, B waits for all of them
    wlog.delete();
    busy_cnt = 0;
    clr_hold = 20;
    bq.push_back('{addr: AW'(6), data: DW'(8'h33)});
    repeat (32) step();
    check("hold_busy_cycles", busy_cnt, 24);
    check("hold_write_cnt", wlog.size(), 25);
    if (wlog.size() >= 25) check("hold_then_b", wlog[24], 8'h33);

    // Reset in the middle of a clear, then a normal B write
    clr_hold = 1;
    repeat (5) step();
    apply_reset(2);
    wlog.delete();
    bq.push_back('{addr: AW'(7), data: DW'(8'hFF)});
    repeat (3) step();
    check("post_rst_cnt", wlog.size(), 1);
    if (wlog.size() >= 1) check("post_rst_data", wlog[0], 8'hFF);

    // Same-address contention right after reset: A first, B wins the file
    apply_reset(1);
    wlog.delete();
    aq.push_back('{addr: AW'(5), data: DW'(8'h11)});
    bq.push_back('{addr: AW'(5), data: DW'(8'h22)});
    repeat (4) step();
    check("same_cnt", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      check("same_first", wlog[0], 8'h11);
      check("same_second", wlog[1], 8'h22);
    end
    check("same_reg5", s_regs[5], 8'h22);

    // Random traffic with occasional clear requests, then drain
    rnd_mode = 1'b1;
    repeat (400) step();
    rnd_mode = 1'b0;
    clr_hold = 0;
    repeat (30) step();

    for (int i = 0; i < int'(NR); i++) check("regfile", s_regs[i], m_regs[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_write_sched.md
# reg_write_sched

Write-port scheduler for the 8×8-bit CPU register file. It shares the file's single write port between two requesters: port A carries ALU writeback and port B carries load/memory writeback. It also runs a sequenced clear engine that zeroes all registers on command. It sits between the writeback sources and the register file's IN/INADDRESS/WRITE inputs, and presents registered write strobes.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 3, register address width
- NREG, 8, number of registers cleared by the clear engine (must equal 2**ADDR_W)

- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- A_VALID  in  1  port A write request
- A_ADDR  in  ADDR_W  port A destination register
- A_DATA  in  DATA_W  port A write data
- A_READY  out  1  port A accepted this cycle (combinational)
- B_VALID  in  1  port B write request
- B_ADDR  in  ADDR_W  port B destination register
- B_DATA  in  DATA_W  port B write data
- B_READY  out  1  port B accepted this cycle (combinational)
- CLEAR_REQ  in  1  request a full register clear (level, sampled)
- CLEAR_BUSY  out  1  clear sequence in progress
- WR_EN  out  1  to register file WRITE (registered)
- WR_ADDR  out  ADDR_W  to register file INADDRESS (registered)
- WR_DATA  out  DATA_W  to register file IN (registered)

## Operation
- FSM states:
  - IDLE: normal arbitration.
  - CLEAR: the clear engine owns the port.
- IDLE → CLEAR when CLEAR_REQ=1 at a posedge.
- CLEAR → IDLE after the write to address NREG-1 has been issued.
- Handshake: a transfer occurs on port X when X_VALID & X_READY are both high at a posedge. Requesters hold ADDR/DATA stable while VALID is high and not yet accepted. VALID is never dropped without a transfer.
- READY generation (combinational):
  - Both READY are 0 in CLEAR, and 0 whenever CLEAR_REQ=1.
  - Otherwise, when only one VALID is high, that port's READY=1.
  - When both are high, round-robin decides.
- Round-robin:
  - A 1-bit LAST register records the last granted port.
  - When both are valid, grant the port ≠ LAST.
  - LAST updates only on a transfer.
  - Reset value: LAST=B, so A wins the first contention.
- A transfer loads WR_EN=1, WR_ADDR=addr and WR_DATA=data. With no transfer and no clear, WR_EN=0 and WR_ADDR/WR_DATA hold their previous values.
- CLEAR behaviour:
  - A 3-bit counter CNT starts at 0.
  - Each cycle it drives WR_EN=1, WR_ADDR=CNT, WR_DATA=0, then increments CNT.
  - The sequence is exactly NREG writes.
- CLEAR_REQ in CLEAR is ignored and does not restart the sequence. If CLEAR_REQ is still high on return to IDLE, a new clear starts.
- Both ports addressing the same register: handled as two ordinary writes in grant order. The later write wins in the file.
- Reset values (asserted asynchronously):
  - state=IDLE, CNT=0, LAST=B
  - WR_EN=0, WR_ADDR=0, WR_DATA=0
  - CLEAR_BUSY=0
- Reset mid-clear aborts the sequence. The registers already zeroed stay zeroed; no resumption after reset.

## Timing
- Write latency is 1 cycle. A transfer at edge k gives WR_EN/WR_ADDR/WR_DATA valid during cycle k+1. The register file commits at edge k+1.
- Throughput is one write per cycle total across both ports. Under continuous contention each port gets every other cycle.
- Clear timing:
  - CLEAR_REQ sampled at edge k.
  - CLEAR_BUSY=1 and WR_EN=1 in cycles k+1 … k+NREG, with addresses 0…NREG-1.
  - READY is low from the cycle CLEAR_REQ rises through cycle k+NREG.
  - IDLE in cycle k+NREG+1, where READY can be high again.
- CLEAR_REQ and VALID arriving in the same cycle: the clear wins and no transfer occurs. The request is accepted after the clear completes.
- Reset deassertion is synchronised externally. The first active edge after deassertion may accept a transfer.

## Structure
- Shared package reg_sched_pkg:
  - state enum {IDLE, CLEAR}
  - port id enum {PORT_A, PORT_B}
  - DATA_W/ADDR_W/NREG defaults
- Sub-module rr_arb2: a 2-requester round-robin arbiter with LAST register, inputs req[1:0] and enable, and one-hot output gnt[1:0]. The FSM and write-port registers stay in reg_write_sched.

## Test plan
- Reset, then A_VALID=1, A_ADDR=3, A_DATA=8'h5A for one cycle → A_READY=1, and the next cycle shows WR_EN=1, WR_ADDR=3, WR_DATA=8'h5A. The following cycle shows WR_EN=0.
- A and B both valid for 4 cycles (A: addr 1 data 10, 11, …; B: addr 2 data 20, 21, …) → grants A, B, A, B. WR_DATA sequence is 10, 20, 11, 21.
- CLEAR_REQ one-cycle pulse with A_VALID held → CLEAR_BUSY high 8 cycles, WR_ADDR 0…7 with WR_DATA=0, A_READY low throughout. A's write is issued in the cycle after CLEAR_BUSY falls.
- CLEAR_REQ held high for 20 cycles → two back-to-back 8-write sequences, and a third begins. No write is ever issued to ports A/B.
- RESET asserted during cycle 4 of a clear → outputs go to 0 immediately and CLEAR_BUSY=0. After release, a B write to addr 7 data 8'hFF completes normally with 1-cycle latency.
- A and B both write addr 5 in contention (A=8'h11, B=8'h22), with LAST=B after reset → WR_DATA order is 8'h11 then 8'h22. The register model ends with 8'h22.
